// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: opcodes, NOP encoding, fetch FSM states, FIFO entry layout.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0]  OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0]  OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0]  OPCODE_BRANCH = 7'b1100011;
    localparam logic [31:0] INSTR_NOP     = 32'h00000013;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } ifu_state_t;

    // One prefetch FIFO entry: instruction word and the PC it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } ifu_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with flush; used for the prefetch buffer and for the in-order PC queue.
// Pop on empty and push on full are not guarded here; the fetch unit's credit rule prevents both.
module ifu_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

    // Next-state for storage, pointers and occupancy; flush wins over push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Storage and pointer registers; storage is cleared so the head reads zero after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: credit-limited requests to instruction memory, prefetch FIFO towards decode,
// redirect handling with discard of wrong-path responses still in flight.
// Optional feature macro: IFU_MISALIGN_TRAP_EN (misaligned redirect raises fetch_fault and halts fetch).
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    // Stale responses in flight are bounded by memory latency; 8 bits covers latencies up to 255 cycles.
    localparam int unsigned DW = 8;

    ifu_state_t    state_q, state_d;
    logic          imem_req_q, imem_req_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [DW-1:0] discard_q, discard_d;

    logic [CW-1:0] data_cnt, data_cnt_nxt;
    logic [CW-1:0] pcq_cnt, pcq_cnt_nxt;
    logic [CW:0]   credit_used;
    logic [31:0]   pcq_head;
    logic [31:0]   target_pc;
    ifu_entry_t    data_wr, data_head;
    logic          gnt_ok, resp_live, data_push, data_pop, pcq_push, data_empty;

    assign gnt_ok     = imem_req_q & imem_gnt;
    assign resp_live  = imem_rvalid & (discard_q == '0);
    assign data_empty = (data_cnt == '0);
    assign data_push  = resp_live & ~redirect;
    assign data_pop   = ~data_empty & instr_ready & ~redirect;
    assign pcq_push   = gnt_ok & ~redirect;
    assign target_pc  = redirect_pc & 32'hFFFF_FFFC;

    assign data_wr.instr = imem_rdata;
    assign data_wr.pc    = pcq_head;

    // PCs of accepted, still-live requests; its occupancy is the live outstanding count.
    ifu_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pc_queue (
        .clk   (clk),
        .reset (reset),
        .flush (redirect),
        .push  (pcq_push),
        .pop   (data_push),
        .wdata (fetch_pc_q),
        .rdata (pcq_head),
        .count (pcq_cnt)
    );

    // Prefetch buffer presenting {instr, pc} to decode.
    ifu_fifo #(.WIDTH($bits(ifu_entry_t)), .DEPTH(DEPTH)) u_prefetch (
        .clk   (clk),
        .reset (reset),
        .flush (redirect),
        .push  (data_push),
        .pop   (data_pop),
        .wdata (data_wr),
        .rdata (data_head),
        .count (data_cnt)
    );

`ifdef IFU_MISALIGN_TRAP_EN
    logic fetch_fault_q, fetch_fault_d;
    assign fetch_fault = fetch_fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

    assign imem_req    = imem_req_q;
    assign imem_addr   = fetch_pc_q;
    assign instr_valid = ~data_empty;
    assign instr       = data_head.instr;
    assign instr_pc    = data_head.pc;

    // Next fetch PC, discard count, FSM state and registered request from next-cycle occupancy.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        discard_d    = discard_q;
`ifdef IFU_MISALIGN_TRAP_EN
        fetch_fault_d = fetch_fault_q;
`endif
        data_cnt_nxt = data_cnt + CW'(data_push) - CW'(data_pop);
        pcq_cnt_nxt  = pcq_cnt + CW'(pcq_push) - CW'(data_push);

        if (gnt_ok) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (imem_rvalid && !resp_live) begin
            discard_d = discard_q - DW'(1);
        end

        if (redirect) begin
            data_cnt_nxt = '0;
            pcq_cnt_nxt  = '0;
            fetch_pc_d   = target_pc;
            // Everything in flight (including a grant this cycle) minus a response retiring now.
            discard_d    = discard_q + DW'(pcq_cnt) + DW'(gnt_ok) - DW'(imem_rvalid);
`ifdef IFU_MISALIGN_TRAP_EN
            if (redirect_pc[1:0] != 2'b00) begin
                state_d       = HALT;
                fetch_fault_d = 1'b1;
            end else begin
                state_d       = RUN;
                fetch_fault_d = 1'b0;
            end
`endif
        end

        credit_used = (CW+1)'(data_cnt_nxt) + (CW+1)'(pcq_cnt_nxt);
        imem_req_d  = (state_d == RUN) && (credit_used < (CW+1)'(DEPTH));
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            imem_req_q <= 1'b0;
            fetch_pc_q <= RESET_PC;
            discard_q  <= '0;
        end else begin
            state_q    <= state_d;
            imem_req_q <= imem_req_d;
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
        end
    end

`ifdef IFU_MISALIGN_TRAP_EN
    // Sticky misalignment trap flag, cleared by the next aligned redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_fault_q <= 1'b0;
        end else begin
            fetch_fault_q <= fetch_fault_d;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: random in-order memory model plus a stream-level reference of
// which PCs decode must see, checked every cycle; directed phases pin the model with literals.
module tb_instr_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fetch_fault;

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_0F96;
    endfunction

    // ---------------- reference model state (owned by the compare process) ----------------
    bit          mdl[$];          // in-flight grants in order; 1 = still on the current path
    int          avail = 0;       // returned on-path words not yet consumed
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] exp_issue = RESET_PC;
    bit          halted = 0;
    bit          fault_exp = 0;
    bit          first_cycle = 1;
    logic [31:0] log_q[$];        // PCs delivered since the last reset/redirect
    int          hs_total = 0;

    function automatic logic [31:0] log_at(input int i);
        if (i < log_q.size()) return log_q[i];
        return 32'hDEAD_BEEF;
    endfunction

    // Compare process: check outputs against the model, then apply this cycle's events.
    initial begin
        int live;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_imem_req", 32'(imem_req), 32'h0);
                chk("rst_imem_addr", imem_addr, RESET_PC);
                chk("rst_instr_valid", 32'(instr_valid), 32'h0);
                chk("rst_instr", instr, 32'h0);
                chk("rst_instr_pc", instr_pc, 32'h0);
                chk("rst_fetch_fault", 32'(fetch_fault), 32'h0);
                mdl.delete();
                log_q.delete();
                avail = 0;
                exp_pc = RESET_PC;
                exp_issue = RESET_PC;
                halted = 0;
                fault_exp = 0;
                first_cycle = 1;
            end else begin
                live = avail;
                foreach (mdl[i]) if (mdl[i]) live++;
                chk("instr_valid", 32'(instr_valid), 32'(avail > 0));
                if (instr_valid && avail > 0) begin
                    chk("instr_pc", instr_pc, exp_pc);
                    chk("instr", instr, mem_word(exp_pc));
                end
                if (!first_cycle) chk("imem_req", 32'(imem_req), 32'(!halted && live < DEPTH));
                if (imem_req) chk("imem_addr", imem_addr, exp_issue);
                chk("fetch_fault", 32'(fetch_fault), 32'(fault_exp));
                first_cycle = 0;

                if (imem_rvalid && mdl.size() > 0) begin
                    if (mdl.pop_front()) avail++;
                end
                if (instr_valid && instr_ready && !redirect) begin
                    log_q.push_back(instr_pc);
                    if (avail > 0) avail--;
                    exp_pc = exp_pc + 32'd4;
                    hs_total++;
                end
                if (imem_req && imem_gnt) begin
                    mdl.push_back(1'b1);
                    exp_issue = exp_issue + 32'd4;
                end
                if (redirect) begin
                    foreach (mdl[i]) mdl[i] = 1'b0;
                    avail = 0;
                    exp_pc = redirect_pc & 32'hFFFF_FFFC;
                    exp_issue = exp_pc;
                    log_q.delete();
`ifdef IFU_MISALIGN_TRAP_EN
                    halted = (redirect_pc[1:0] != 2'b00);
                    fault_exp = halted;
`endif
                end
            end
        end
    end

    // ---------------- stimulus: memory model and decode/redirect driver ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          cyc = 0;
    int          gnt_pct = 100, rdy_pct = 100, redir_pct = 0, lat_min = 1, lat_max = 1;
    bit          force_redir = 0, redir_both = 0, last_gnt = 0;
    logic [31:0] force_pc = '0;

    task automatic cycle();
        bit          rv, g;
        logic [31:0] ra, rp;
        @(posedge clk);
        #1;
        cyc++;
        rv = 0;
        ra = '0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            rv = 1;
            ra = mq[0].addr;
            void'(mq.pop_front());
        end
        imem_rvalid = rv;
        imem_rdata  = rv ? mem_word(ra) : $urandom;
        g = imem_req && ($urandom_range(99) < gnt_pct);
        imem_gnt = g;
        last_gnt = g;
        if (g) mq.push_back('{addr: imem_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
        instr_ready = ($urandom_range(99) < rdy_pct);
        redirect = 0;
        redirect_pc = $urandom;
        if (redir_both && g && rv) begin
            redirect = 1;
            redirect_pc = force_pc;
            redir_both = 0;
        end else if (force_redir) begin
            redirect = 1;
            redirect_pc = force_pc;
            force_redir = 0;
        end else if ($urandom_range(99) < redir_pct) begin
            rp = $urandom & 32'h0000_3FFC;
            if ($urandom_range(3) == 0) rp[1:0] = 2'($urandom_range(3, 1));
            redirect = 1;
            redirect_pc = rp;
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        reset = 1;
        imem_gnt = 0;
        imem_rvalid = 0;
        instr_ready = 0;
        redirect = 0;
        mq.delete();
        repeat (3) @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        force_pc = pc;
        force_redir = 1;
        cycle();
    endtask

    task automatic set_mode(input int g, input int r, input int lmin, input int lmax, input int rd);
        gnt_pct = g;
        rdy_pct = r;
        lat_min = lmin;
        lat_max = lmax;
        redir_pct = rd;
    endtask

    initial begin
        int grants;
        #1;
        do_reset();

        // Streaming from reset: 0x0, 0x4, 0x8 in order.
        set_mode(100, 100, 1, 1, 0);
        run(20);
        chk("t1_pc0", log_at(0), 32'h0000_0000);
        chk("t1_pc1", log_at(1), 32'h0000_0004);
        chk("t1_pc2", log_at(2), 32'h0000_0008);

        // Decode stall: credit stops fetch after DEPTH words.
        set_mode(100, 0, 1, 1, 0);
        grants = 0;
        repeat (10) begin
            cycle();
            if (last_gnt) grants++;
        end
        chk("t2_grants_le_depth", 32'(grants <= DEPTH), 32'h1);
        chk("t2_req_low", 32'(imem_req), 32'h0);
        chk("t2_valid_held", 32'(instr_valid), 32'h1);
        set_mode(100, 100, 1, 1, 0);
        run(10);

        // Redirect with two requests in flight.
        set_mode(100, 100, 3, 3, 0);
        run(6);
        for (int i = 0; i < 20 && mq.size() < 2; i++) cycle();
        chk("t3_two_outstanding", 32'(mq.size() >= 2), 32'h1);
        do_redirect(32'h0000_0100);
        run(15);
        chk("t3_first_pc", log_at(0), 32'h0000_0100);

        // Redirect coinciding with both a grant and a response.
        set_mode(100, 100, 1, 1, 0);
        force_pc = 32'h0000_0180;
        redir_both = 1;
        for (int i = 0; i < 50 && redir_both; i++) cycle();
        chk("t4_coincidence_hit", 32'(redir_both), 32'h0);
        run(15);
        chk("t4_first_pc", log_at(0), 32'h0000_0180);

        // Back-to-back redirects under 3-cycle latency.
        set_mode(100, 100, 3, 3, 0);
        run(5);
        do_redirect(32'h0000_0200);
        do_redirect(32'h0000_0300);
        run(20);
        chk("t5_first_pc", log_at(0), 32'h0000_0300);
        chk("t5_second_pc", log_at(1), 32'h0000_0304);

        // Misaligned redirect.
        set_mode(100, 100, 2, 2, 0);
        do_redirect(32'h0000_0102);
`ifdef IFU_MISALIGN_TRAP_EN
        run(4);
        chk("t6_fault_set", 32'(fetch_fault), 32'h1);
        chk("t6_req_halted", 32'(imem_req), 32'h0);
        chk("t6_valid_halted", 32'(instr_valid), 32'h0);
        do_redirect(32'h0000_0104);
        run(15);
        chk("t6_fault_clear", 32'(fetch_fault), 32'h0);
        chk("t6_resume_pc", log_at(0), 32'h0000_0104);
`else
        run(15);
        chk("t6_fault_zero", 32'(fetch_fault), 32'h0);
        chk("t6_masked_pc", log_at(0), 32'h0000_0100);
`endif

        // Fetch PC wraps modulo 2^32.
        set_mode(100, 100, 1, 1, 0);
        do_redirect(32'hFFFF_FFF8);
        run(20);
        chk("wrap_pc0", log_at(0), 32'hFFFF_FFF8);
        chk("wrap_pc2", log_at(2), 32'h0000_0000);

        // Reset mid-transfer abandons outstanding responses.
        set_mode(100, 100, 3, 3, 0);
        run(7);
        do_reset();
        set_mode(100, 100, 1, 1, 0);
        run(12);
        chk("rst_mid_pc0", log_at(0), RESET_PC);

        // Randomized traffic.
        for (int blk = 0; blk < 15; blk++) begin
            set_mode(int'($urandom_range(100, 30)), int'($urandom_range(100, 20)), 1,
                     int'($urandom_range(5, 1)), int'($urandom_range(6, 0)));
            run(200);
            if (blk == 7) do_reset();
        end
        set_mode(100, 100, 1, 1, 0);
        do_redirect(32'h0000_0400);
        run(20);
        chk("final_pc", log_at(0), 32'h0000_0400);
        chk("progress", 32'(hs_total > 500), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
